// File: rtl/cache_read_arbiter_pkg.sv
// Shared types and constants for the icache/dcache read-port arbiter.
package cache_read_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam int BURST_BEATS = 4;
  localparam int LANE_W      = 32;
  localparam int LINE_W      = BURST_BEATS * LANE_W;

  localparam logic GRANT_CODE = 1'b0;
  localparam logic GRANT_LINE = 1'b1;

  typedef struct packed {
    logic        pend;
    logic [31:0] addr;
  } req_t;

  // The code side starts on the requested dword, the line side on the line base.
  function automatic logic [31:0] burst_mask(input logic is_line);
    return is_line ? 32'hFFFF_FFF0 : 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cache_read_line_buf.sv
// Beat counter and lane-scattering line register for the single active wrap burst.
module cache_read_line_buf
  import cache_read_arbiter_pkg::*;
#(
  parameter int NUM_LANES = BURST_BEATS,
  parameter int VEC_W     = LANE_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic [$clog2(NUM_LANES)-1:0]        start_lane,
  input  logic                                beat_vld,
  input  logic [VEC_W-1:0]                    beat_data,
  output logic                                last_beat,
  output logic [NUM_LANES-1:0][VEC_W-1:0]     line_nxt
);

  localparam int LW = $clog2(NUM_LANES);

  logic [LW-1:0]                    cnt_q;
  logic [LW-1:0]                    base_q;
  logic [LW-1:0]                    lane;
  logic [NUM_LANES-1:0][VEC_W-1:0]  line_q;

  // Lane index wraps naturally in LW bits, matching the memory's wrap order.
  assign lane      = base_q + cnt_q;
  assign last_beat = beat_vld && (cnt_q == LW'(NUM_LANES - 1));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign line_nxt[i] = (beat_vld && lane == LW'(i)) ? beat_data : line_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      base_q <= '0;
      line_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      base_q <= start_lane;
      line_q <= '0;
    end else if (beat_vld) begin
      cnt_q  <= cnt_q + 1'b1;
      line_q <= line_nxt;
    end
  end

endmodule

// File: rtl/cache_read_arbiter.sv
// Arbitrates icache readcode and dcache readline onto one 4-beat wrap-burst read port.
module cache_read_arbiter
  import cache_read_arbiter_pkg::*;
#(
  parameter bit DCACHE_PRIORITY = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               readcode_do,
  input  logic [31:0]        readcode_address,
  output logic               readcode_partial_done,
  output logic [31:0]        readcode_partial,
  output logic               readcode_done,
  output logic [LINE_W-1:0]  readcode_line,
  input  logic               readline_do,
  input  logic [31:0]        readline_address,
  output logic               readline_done,
  output logic [LINE_W-1:0]  readline_line,
  output logic               mem_read,
  output logic [31:0]        mem_address,
  output logic [2:0]         mem_burstcount,
  input  logic               mem_waitrequest,
  input  logic [31:0]        mem_readdata,
  input  logic               mem_readdatavalid
);

  state_t state, state_nxt;
  req_t   code_req, line_req;
  logic   act_grant, last_grant;
  logic   any_pend, grant_sel, grant_go, beat_vld, last_beat;
  logic   code_busy, line_busy;
  logic [31:0] sel_addr, burst_addr;
  logic [BURST_BEATS-1:0][LANE_W-1:0] line_nxt;

  assign any_pend  = code_req.pend | line_req.pend;
  // Round-robin prefers the side not served last; priority mode always favours the dcache.
  assign grant_sel = line_req.pend &
                     (~code_req.pend | DCACHE_PRIORITY | (last_grant == GRANT_CODE));
  assign grant_go  = (state == S_IDLE) & any_pend;
  assign beat_vld  = (state == S_DATA) & mem_readdatavalid;
  assign code_busy = (state != S_IDLE) & (act_grant == GRANT_CODE);
  assign line_busy = (state != S_IDLE) & (act_grant == GRANT_LINE);
  assign sel_addr  = (grant_sel == GRANT_LINE) ? line_req.addr : code_req.addr;
  assign burst_addr = sel_addr & burst_mask(grant_sel);

  cache_read_line_buf #(.NUM_LANES(BURST_BEATS), .VEC_W(LANE_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (grant_go),
    .start_lane (burst_addr[3:2]),
    .beat_vld   (beat_vld),
    .beat_data  (mem_readdata),
    .last_beat  (last_beat),
    .line_nxt   (line_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_pend)         state_nxt = S_CMD;
      S_CMD:   if (!mem_waitrequest) state_nxt = S_DATA;
      S_DATA:  if (last_beat)        state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // A repeat pulse from a requester already pending or in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_req <= '0;
      line_req <= '0;
    end else begin
      if (grant_go && grant_sel == GRANT_CODE)
        code_req.pend <= 1'b0;
      else if (readcode_do && !code_req.pend && !code_busy)
        code_req <= '{pend: 1'b1, addr: readcode_address};
      if (grant_go && grant_sel == GRANT_LINE)
        line_req.pend <= 1'b0;
      else if (readline_do && !line_req.pend && !line_busy)
        line_req <= '{pend: 1'b1, addr: readline_address};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_grant      <= GRANT_CODE;
      last_grant     <= GRANT_CODE;
      mem_read       <= 1'b0;
      mem_address    <= '0;
      mem_burstcount <= '0;
    end else if (grant_go) begin
      act_grant      <= grant_sel;
      last_grant     <= grant_sel;
      mem_read       <= 1'b1;
      mem_address    <= burst_addr;
      mem_burstcount <= 3'(BURST_BEATS);
    end else if (state == S_CMD && !mem_waitrequest) begin
      mem_read       <= 1'b0;
      mem_burstcount <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readcode_partial_done <= 1'b0;
      readcode_partial      <= '0;
      readcode_done         <= 1'b0;
      readcode_line         <= '0;
      readline_done         <= 1'b0;
      readline_line         <= '0;
    end else begin
      readcode_partial_done <= 1'b0;
      readcode_done         <= 1'b0;
      readline_done         <= 1'b0;
      if (beat_vld && act_grant == GRANT_CODE) begin
        readcode_partial      <= mem_readdata;
        readcode_partial_done <= ~last_beat;
        readcode_done         <= last_beat;
        if (last_beat) readcode_line <= line_nxt;
      end
      if (beat_vld && act_grant == GRANT_LINE && last_beat) begin
        readline_done <= 1'b1;
        readline_line <= line_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Scoreboard bench: bus/request model predicts grants and line contents, monitor compares outputs.
module tb_cache_read_arbiter;

  localparam bit PRIO = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         readcode_do, readline_do;
  logic [31:0]  readcode_address, readline_address;
  logic         readcode_partial_done, readcode_done, readline_done;
  logic [31:0]  readcode_partial;
  logic [127:0] readcode_line, readline_line;
  logic         mem_read, mem_waitrequest, mem_readdatavalid;
  logic [31:0]  mem_address, mem_readdata;
  logic [2:0]   mem_burstcount;
  logic [326:0] all_out;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_read_arbiter #(.DCACHE_PRIORITY(PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .readcode_do(readcode_do), .readcode_address(readcode_address),
    .readcode_partial_done(readcode_partial_done), .readcode_partial(readcode_partial),
    .readcode_done(readcode_done), .readcode_line(readcode_line),
    .readline_do(readline_do), .readline_address(readline_address),
    .readline_done(readline_done), .readline_line(readline_line),
    .mem_read(mem_read), .mem_address(mem_address), .mem_burstcount(mem_burstcount),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  assign all_out = {readcode_partial_done, readcode_partial, readcode_done, readcode_line,
                    readline_done, readline_line, mem_read, mem_address, mem_burstcount};

  typedef struct { bit fin; logic [31:0] data; logic [127:0] line; int cyc; } exp_t;
  exp_t code_q[$], line_q[$];
  int checks = 0, errors = 0;
  logic [127:0] hold_code, hold_line;

  // request / bus model state
  bit          code_out, line_out, active, act_code, fin_pend, last_line, cmd_seen;
  bit          prev_read, prev_wait;
  logic [31:0] code_start, line_start, act_start, prev_addr, last_cmd_addr;
  int          code_iss, line_iss, last_final, beat_k, beat_limit, beat_ok_cyc;
  int          wait_left, force_wait, rises, rise_gap, hold_seen;
  logic [31:0] lanes [4];
  logic [31:0] data_q[$];
  bit          glog[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit code_busy();
    return code_out || (active && act_code);
  endfunction
  function automatic bit line_busy();
    return line_out || (active && !act_code);
  endfunction

  task automatic model_reset();
    code_out = 0; line_out = 0; active = 0; fin_pend = 0; last_line = 0; cmd_seen = 0;
    prev_read = 0; prev_wait = 0; last_final = -100; beat_limit = 4; force_wait = -1;
    code_q.delete(); line_q.delete(); data_q.delete();
  endtask

  task automatic issue_code(input logic [31:0] a);
    readcode_do = 1; readcode_address = a;
    code_out = 1; code_start = a & ~32'h3; code_iss = cyc;
  endtask
  task automatic issue_line(input logic [31:0] a);
    readline_do = 1; readline_address = a;
    line_out = 1; line_start = a & ~32'hF; line_iss = cyc;
  endtask

  // A new command must follow the rules: latency from the oldest request or last final beat,
  // winner by pending set and round-robin state.
  task automatic on_rise();
    int mn, exp_r;
    bit ec, el, pl;
    logic [31:0] ea;
    rises++;
    chk("cmd_overlap", active, 1'b0);
    if (!code_out && !line_out) chk("cmd_spurious", mem_read, 1'b0);
    else begin
      mn = code_out ? code_iss : line_iss;
      if (code_out && line_out && line_iss < code_iss) mn = line_iss;
      exp_r = (mn + 2 > last_final + 2) ? mn + 2 : last_final + 2;
      chk("cmd_latency", cyc, exp_r);
      ec = code_out && code_iss <= cyc - 2;
      el = line_out && line_iss <= cyc - 2;
      if (!ec && !el) begin ec = code_out; el = line_out; end
      pl = el && (!ec || PRIO || !last_line);
      ea = pl ? line_start : code_start;
      if (pl) line_out = 0; else code_out = 0;
      chk("cmd_addr", mem_address, ea);
      rise_gap = cyc - last_final;
      last_cmd_addr = mem_address;
      active = 1; act_code = !pl; act_start = ea; beat_k = 0; last_line = pl;
      for (int i = 0; i < 4; i++) lanes[i] = '0;
      glog.push_back(pl);
      beat_ok_cyc = 1 << 30;
    end
  endtask

  task automatic step();
    logic [31:0] d;
    int lane;
    @(negedge clk);
    readcode_do = 0; readline_do = 0;
    readcode_address = $urandom; readline_address = $urandom;
    mem_readdatavalid = 0; mem_readdata = $urandom;
    if (fin_pend) begin active = 0; fin_pend = 0; end
    if (prev_read && prev_wait) begin
      hold_seen++;
      chk("cmd_hold", {mem_read, mem_address}, {1'b1, prev_addr});
    end
    if (prev_read && !prev_wait) chk("cmd_drop", mem_read, 1'b0);
    if (mem_read) chk("burstcount", mem_burstcount, 3'd4);
    if (mem_read && !cmd_seen) begin
      on_rise();
      cmd_seen = 1;
      wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
      force_wait = -1;
    end
    if (mem_read) begin
      mem_waitrequest = (wait_left > 0);
      if (wait_left > 0) wait_left--;
      else begin cmd_seen = 0; beat_ok_cyc = cyc + 1; end
    end else mem_waitrequest = 1'($urandom_range(0, 1));
    if (active && cyc >= beat_ok_cyc && beat_k < beat_limit && $urandom_range(0, 2) != 0) begin
      d = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
      mem_readdatavalid = 1; mem_readdata = d;
      lane = (int'(act_start[3:2]) + beat_k) % 4;
      lanes[lane] = d;
      if (act_code)
        code_q.push_back('{fin: (beat_k == 3), data: d,
                           line: {lanes[3], lanes[2], lanes[1], lanes[0]}, cyc: cyc + 1});
      else if (beat_k == 3)
        line_q.push_back('{fin: 1'b1, data: 32'h0,
                           line: {lanes[3], lanes[2], lanes[1], lanes[0]}, cyc: cyc + 1});
      if (beat_k == 3) begin last_final = cyc; fin_pend = 1; end
      beat_k++;
    end else if (!(active && cyc >= beat_ok_cyc) && $urandom_range(0, 3) == 0)
      mem_readdatavalid = 1;  // stray beat outside a data phase
    prev_read = mem_read; prev_wait = mem_waitrequest; prev_addr = mem_address;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((active || code_out || line_out) && n < 400) begin step(); n++; end
    if (n >= 400) chk(name, {active, code_out, line_out}, 3'b000);
    step(); step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_code = '0; hold_line = '0;
    end else begin
      if (readcode_partial_done || readcode_done) begin
        if (code_q.size() == 0)
          chk("code_unexpected", {readcode_partial_done, readcode_done}, 2'b00);
        else begin
          e = code_q.pop_front();
          chk("code_cycle", cyc, e.cyc);
          chk("code_kind", {readcode_partial_done, readcode_done}, e.fin ? 2'b01 : 2'b10);
          chk("code_data", readcode_partial, e.data);
          if (e.fin) begin chk("code_line", readcode_line, e.line); hold_code = e.line; end
        end
      end
      if (readline_done) begin
        if (line_q.size() == 0) chk("line_unexpected", readline_done, 1'b0);
        else begin
          e = line_q.pop_front();
          chk("line_cycle", cyc, e.cyc);
          chk("line_line", readline_line, e.line);
          hold_line = e.line;
        end
      end
    end
  end

  initial begin
    int n, r0, h0;
    readcode_do = 0; readline_do = 0; readcode_address = 0; readline_address = 0;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = 0;
    rises = 0; hold_seen = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", |all_out, 1'b0);
    rst_n = 1;
    step();

    data_q = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    issue_line(32'h0000_2004);
    wait_idle("line_timeout");
    chk("line_cmd_addr", last_cmd_addr, 32'h0000_2000);
    chk("line_value", readline_line,
        128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);

    data_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    issue_code(32'h0000_1008);
    wait_idle("code_timeout");
    chk("code_cmd_addr", last_cmd_addr, 32'h0000_1008);
    chk("code_value", readcode_line, 128'h00000022_00000011_00000044_00000033);

    glog.delete();
    issue_code(32'h0000_3004); issue_line(32'h0000_4000);
    wait_idle("pair1_timeout");
    issue_line(32'h0000_4010);
    wait_idle("solo_timeout");
    issue_code(32'h0000_3008); issue_line(32'h0000_4020);
    wait_idle("pair2_timeout");
    chk("rr_count", glog.size(), 5);
    chk("rr_order", {glog[0], glog[1], glog[2], glog[3], glog[4]}, 5'b10101);

    r0 = rises; h0 = hold_seen; force_wait = 5;
    issue_code(32'h0000_5010);
    wait_idle("wait_timeout");
    chk("wait_one_cmd", rises - r0, 1);
    chk("wait_hold_cycles", hold_seen - h0, 5);

    issue_code(32'h0000_6004);
    n = 0;
    while (!(active && act_code && beat_k >= 1) && n < 200) begin step(); n++; end
    if (n >= 200) chk("mid_timeout", beat_k, 1);
    issue_line(32'h0000_7008);
    wait_idle("mid_done_timeout");
    chk("mid_gap", rise_gap, 2);
    chk("mid_line_last", glog[glog.size() - 1], 1'b1);

    beat_limit = 3;
    issue_code(32'h0000_8008);
    n = 0;
    while (!(active && beat_k == 3) && n < 200) begin step(); n++; end
    if (n >= 200) chk("rst_timeout", beat_k, 3);
    issue_line(32'h0000_9000);
    step(); step();
    #2 rst_n = 0;
    #1 chk("reset_async", |all_out, 1'b0);
    model_reset();
    repeat (5) step();
    rst_n = 1;
    r0 = rises;
    repeat (10) step();
    chk("reset_no_cmd", rises - r0, 0);
    issue_code(32'h0000_8008);
    wait_idle("post_reset_timeout");
    chk("post_reset_grant", glog[glog.size() - 1], 1'b0);
    chk("post_reset_line", readcode_line, hold_code);

    repeat (800) begin
      step();
      if (!code_busy() && $urandom_range(0, 5) == 0) issue_code($urandom);
      if (!line_busy() && $urandom_range(0, 5) == 0) issue_line($urandom);
    end
    wait_idle("random_timeout");

    chk("code_q_drained", code_q.size(), 0);
    chk("line_q_drained", line_q.size(), 0);
    chk("code_line_hold", readcode_line, hold_code);
    chk("line_line_hold", readline_line, hold_line);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
